// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with one-shot / auto-reload expiry pulses.
// Optional shared tick prescaler enabled by defining TIMER_PRESCALER_EN.
module multi_timer #(
  parameter int WIDTH      = 9,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      count_en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  input  logic [CHANNELS-1:0]       auto_reload,
  input  logic [CHANNELS-1:0]       stop,
`ifdef TIMER_PRESCALER_EN
  input  logic [PRESCALE_W-1:0]     prescale,
`endif
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*WIDTH-1:0] count
);

  typedef enum logic {IDLE, RUN} state_t;

  logic tick;

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] pre_cnt;

  // Free-running divider: never reset by loads, wraps to 0 on each tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (count_en) begin
      if (pre_cnt == prescale) pre_cnt <= '0;
      else                     pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end

  assign tick = count_en && (pre_cnt == prescale);
`else
  assign tick = count_en;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] reload;
    logic             mode;
    logic             pulse;
    logic [WIDTH-1:0] lv;

    assign lv = load_value[g*WIDTH +: WIDTH];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        cnt    <= '0;
        reload <= '0;
        mode   <= 1'b0;
        pulse  <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (load[g]) begin
          cnt    <= lv;
          reload <= lv;
          mode   <= auto_reload[g];
          // A zero period expires immediately and never enters RUN.
          if (lv != '0) begin
            state <= RUN;
          end else begin
            state <= IDLE;
            pulse <= 1'b1;
          end
        end else if (stop[g]) begin
          if (state == RUN) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end else if (tick && state == RUN) begin
          if (cnt > WIDTH'(1)) begin
            cnt <= cnt - WIDTH'(1);
          end else begin
            pulse <= 1'b1;
            if (mode) begin
              cnt <= reload;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
      end
    end

    assign out[g]                   = pulse;
    assign busy[g]                  = (state == RUN);
    assign count[g*WIDTH +: WIDTH]  = cnt;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer (default build, no prescaler).
module tb_multi_timer;
  localparam int W  = 9;
  localparam int CH = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              count_en = 1'b0;
  logic [CH-1:0]     load = '0;
  logic [CH*W-1:0]   load_value = '0;
  logic [CH-1:0]     auto_reload = '0;
  logic [CH-1:0]     stop = '0;
  logic [CH-1:0]     out;
  logic [CH-1:0]     busy;
  logic [CH*W-1:0]   count;

  multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(4)) dut (
    .clock(clock), .reset(reset), .count_en(count_en), .load(load),
    .load_value(load_value), .auto_reload(auto_reload), .stop(stop),
    .out(out), .busy(busy), .count(count)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model: remaining ticks until expiry per channel (0 = idle).
  int rem[CH];
  int period[CH];
  bit periodic[CH];
  bit exp_out[CH];

  int pulses[CH];
  int last_pulse[CH];
  int t0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      rem[i] = 0; period[i] = 0; periodic[i] = 0; exp_out[i] = 0;
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0]   eo, eb;
    logic [CH*W-1:0] ec;
    for (int i = 0; i < CH; i++) begin
      eo[i] = exp_out[i];
      eb[i] = (rem[i] > 0);
      ec[i*W +: W] = rem[i][W-1:0];
    end
    check("out", 64'(out), 64'(eo));
    check("busy", 64'(busy), 64'(eb));
    check("count", 64'(count), 64'(ec));
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < CH; i++) begin
        exp_out[i] = 0;
        if (load[i]) begin
          period[i]   = int'(load_value[i*W +: W]);
          periodic[i] = auto_reload[i];
          rem[i]      = period[i];
          if (period[i] == 0) exp_out[i] = 1;
        end else if (stop[i]) begin
          rem[i] = 0;
        end else if (count_en && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) begin
            exp_out[i] = 1;
            if (periodic[i]) rem[i] = period[i];
          end
        end
      end
    end
    #1;
    compare_all();
    for (int i = 0; i < CH; i++)
      if (out[i] === 1'b1) begin pulses[i]++; last_pulse[i] = cyc; end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input int ch, input int val, input bit ar);
    load[ch] = 1'b1;
    load_value[ch*W +: W] = W'(val);
    auto_reload[ch] = ar;
    step();
    load[ch] = 1'b0;
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < CH; i++) begin pulses[i] = 0; last_pulse[i] = -1; end
  endtask

  initial begin
    model_reset();
    clear_pulses();

    // Reset held with activity on every input
    count_en = 1'b1; load = '1; auto_reload = '1;
    for (int i = 0; i < CH; i++) load_value[i*W +: W] = W'(i + 3);
    steps(3);
    load = '0; auto_reload = '0;
    #2 reset = 1'b1;
    steps(4);
    check("idle_after_reset_busy", 64'(busy), 64'(0));

    // One-shot ch0 = 5
    clear_pulses();
    do_load(0, 5, 1'b0);
    t0 = cyc;
    steps(10);
    check("oneshot_pulses", 64'(pulses[0]), 64'(1));
    check("oneshot_latency", 64'(last_pulse[0] - t0), 64'(5));

    // Auto-reload ch1 = 3 for 12 cycles
    clear_pulses();
    do_load(1, 3, 1'b1);
    t0 = cyc;
    steps(12);
    check("reload_pulses", 64'(pulses[1]), 64'(4));
    check("reload_last", 64'(last_pulse[1] - t0), 64'(12));
    stop[1] = 1'b1; step(); stop[1] = 1'b0;

    // Restart ch2: 10, then 2 after 4 ticks
    clear_pulses();
    do_load(2, 10, 1'b0);
    steps(4);
    do_load(2, 2, 1'b0);
    t0 = cyc;
    steps(12);
    check("restart_pulses", 64'(pulses[2]), 64'(1));
    check("restart_latency", 64'(last_pulse[2] - t0), 64'(2));

    // Stop ch3 after 2 ticks
    clear_pulses();
    do_load(3, 6, 1'b0);
    steps(2);
    stop[3] = 1'b1; step(); stop[3] = 1'b0;
    check("stop_busy", 64'(busy[3]), 64'(0));
    check("stop_count", 64'(count[3*W +: W]), 64'(0));
    steps(8);
    check("stop_pulses", 64'(pulses[3]), 64'(0));

    // Load 0: immediate pulse, never busy
    clear_pulses();
    do_load(0, 0, 1'b1);
    check("zero_out", 64'(out[0]), 64'(1));
    check("zero_busy", 64'(busy[0]), 64'(0));
    steps(3);
    check("zero_pulses", 64'(pulses[0]), 64'(1));

    // Maximum period
    clear_pulses();
    do_load(1, 511, 1'b0);
    t0 = cyc;
    steps(515);
    check("max_latency", 64'(last_pulse[1] - t0), 64'(511));
    check("max_pulses", 64'(pulses[1]), 64'(1));

    // Simultaneous loads on ch0 and ch1
    clear_pulses();
    load[0] = 1'b1; load[1] = 1'b1;
    load_value[0 +: W] = W'(4); load_value[W +: W] = W'(4);
    auto_reload[0] = 1'b0; auto_reload[1] = 1'b0;
    step();
    load = '0;
    steps(6);
    check("simul_same_cycle", 64'(last_pulse[0]), 64'(last_pulse[1]));
    check("simul_pulses", 64'(pulses[0] + pulses[1]), 64'(2));

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      count_en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < CH; i++) begin
        load[i] = ($urandom_range(0, 15) == 0);
        stop[i] = ($urandom_range(0, 19) == 0);
        auto_reload[i] = $urandom_range(0, 1) != 0;
        load_value[i*W +: W] = W'($urandom_range(0, 12));
      end
      step();
    end
    load = '0; stop = '0; count_en = 1'b1;

    // Asynchronous reset mid-count
    do_load(0, 100, 1'b1);
    steps(3);
    #3 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    steps(2);
    #2 reset = 1'b1;
    clear_pulses();
    steps(5);
    check("no_pulse_after_reset", 64'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
